instr_fetch_unit: RTL

Byte-serial instruction fetch stage that sits directly upstream of the single-cycle core's decode/execute datapath. It reads four consecutive bytes from the byte-wide instruction memory and assembles them big-endian into a 32-bit instruction. It presents the instruction, its PC and PC+4 to the core over a valid/ready handshake. The core can redirect fetch (branch, jump, bgtzal, brnv targets) at any time.

---
 rtl/ifu_pkg.sv | 13 +
 rtl/ifu_word_assembler.sv | 36 +++
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: fetch FSM state codes, word geometry and the word/PC record shared by the fetch unit
package ifu_pkg;
    typedef logic [1:0] ifu_state_t;
    localparam ifu_state_t  ST_FETCH   = 2'd0;
    localparam ifu_state_t  ST_WAIT    = 2'd1;
    localparam ifu_state_t  ST_HOLD    = 2'd2;
    localparam int          INST_BYTES = 4;
    localparam logic [31:0] PC_STEP    = 32'd4;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ifu_word_t;
endpackage

// File: rtl/ifu_word_assembler.sv
// ifu_word_assembler: shifts returning memory bytes into a big-endian word and pulses word_done
module ifu_word_assembler
    import ifu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_issue,
    input  logic        i_flush,
    input  logic [7:0]  i_rdata,
    output logic        o_word_done,
    output logic [31:0] o_word
);
    logic        r_due;
    logic [1:0]  r_cnt;
    logic [23:0] r_sh;

    // r_due marks a byte arriving this cycle; a flush discards the byte still in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_due <= 1'b0;
            r_cnt <= '0;
            r_sh  <= '0;
        end else begin
            r_due <= i_issue && !i_flush;
            if (i_flush) begin
                r_cnt <= '0;
            end else if (r_due) begin
                r_cnt <= r_cnt + 2'd1;
                r_sh  <= {r_sh[15:0], i_rdata};
            end
        end
    end

    assign o_word_done = r_due && (r_cnt == 2'(INST_BYTES - 1)) && !i_flush;
    assign o_word      = {r_sh, i_rdata};
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: byte-serial fetch of big-endian 32-bit words with valid/ready output and redirect;
// define IFU_PREFETCH_EN to add a one-word skid buffer and keep issuing while a word is held
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [7:0]        i_imem_rdata,
    input  logic              i_redirect_valid,
    input  logic [31:0]       i_redirect_pc,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [31:0]       o_inst,
    output logic [31:0]       o_inst_pc,
    output logic [31:0]       o_inst_pc4
);
    ifu_state_t  r_state;
    logic [1:0]  r_k;
    logic [31:0] r_fpc;
    logic        r_pend;
    logic        r_out_v;
    ifu_word_t   r_out;
    logic        w_room;
    logic        w_issue;
    logic        w_hs;
    logic        w_done;
    logic [31:0] w_word;
    ifu_word_t   w_new;

`ifdef IFU_PREFETCH_EN
    logic      r_skid_v;
    ifu_word_t r_skid;
    localparam ifu_state_t ST_AFTER_LAST = ST_FETCH;
    // a new word may only start if every word already in flight or held still has a slot
    assign w_room = (r_k != 2'd0) || !r_out_v || (!r_skid_v && !r_pend);
`else
    localparam ifu_state_t ST_AFTER_LAST = ST_WAIT;
    assign w_room = 1'b1;
`endif

    assign w_issue      = (r_state == ST_FETCH) && w_room;
    assign o_imem_req   = i_rst_n && w_issue;
    assign o_imem_addr  = r_fpc[ADDR_W-1:0] + ADDR_W'(r_k);
    assign w_hs         = r_out_v && i_inst_ready;
    assign w_new        = {w_word, r_fpc - PC_STEP};
    assign o_inst_valid = r_out_v;
    assign o_inst       = r_out.inst;
    assign o_inst_pc    = r_out.pc;
    assign o_inst_pc4   = r_out.pc + PC_STEP;

    ifu_word_assembler u_asm (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_issue     (w_issue),
        .i_flush     (i_redirect_valid),
        .i_rdata     (i_imem_rdata),
        .o_word_done (w_done),
        .o_word      (w_word)
    );

    // fetch FSM, byte counter and fetch PC; fpc moves on once the last byte of a word is issued
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_FETCH;
            r_k     <= '0;
            r_fpc   <= RESET_PC;
            r_pend  <= 1'b0;
        end else if (i_redirect_valid) begin
            r_state <= ST_FETCH;
            r_k     <= '0;
            r_fpc   <= i_redirect_pc & ~32'd3;
            r_pend  <= 1'b0;
        end else begin
            if (w_issue) r_k <= r_k + 2'd1;
            if (w_issue && r_k == 2'd3) begin
                r_fpc   <= r_fpc + PC_STEP;
                r_pend  <= 1'b1;
                r_state <= ST_AFTER_LAST;
            end else if (w_done) begin
                r_pend  <= 1'b0;
                r_state <= (r_state == ST_WAIT) ? ST_HOLD : r_state;
            end else if (w_hs && r_state == ST_HOLD) begin
                r_state <= ST_FETCH;
            end
        end
    end

    // presented word (and skid slot when prefetching); a redirect drops everything held
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_v  <= 1'b0;
            r_out    <= {32'd0, RESET_PC};
`ifdef IFU_PREFETCH_EN
            r_skid_v <= 1'b0;
            r_skid   <= '0;
`endif
        end else if (i_redirect_valid) begin
            r_out_v  <= 1'b0;
`ifdef IFU_PREFETCH_EN
            r_skid_v <= 1'b0;
`endif
        end else begin
`ifdef IFU_PREFETCH_EN
            if (w_hs && r_skid_v) begin
                r_out    <= r_skid;
                r_skid_v <= w_done;
                if (w_done) r_skid <= w_new;
            end else if (w_hs || !r_out_v) begin
                r_out_v <= w_done;
                if (w_done) r_out <= w_new;
            end else if (w_done) begin
                r_skid_v <= 1'b1;
                r_skid   <= w_new;
            end
`else
            if (w_done) begin
                r_out_v <= 1'b1;
                r_out   <= w_new;
            end else if (w_hs) begin
                r_out_v <= 1'b0;
            end
`endif
        end
    end
endmodule
